// File: rtl/jar_pi_pkg.sv
// Shared types and constants for the pi digit reader.
package jar_pi_pkg;

    localparam int unsigned IDX_W   = 9;
    localparam int unsigned CHUNK_W = 5;

    typedef enum logic [2:0] {
        StIdle,
        StLoadLo,
        StLoadHi,
        StSettle,
        StStream
    } state_t;

    // Active-high g..a glyphs; entry i is the pattern for hex digit i.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/jar_seg7dec.sv
// Combinational 7-segment pattern to hex decoder; unmatched patterns flag err.
module jar_seg7dec
    import jar_pi_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       err
);

    // Search the glyph table; no hit leaves hex at 0 with err set.
    always_comb begin
        hex = 4'd0;
        err = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPH_TABLE[i]) begin
                hex = 4'(i);
                err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/jar_pi_reader.sv
// Loads a start index into the pi digit block, streams N digits and decodes them.
module jar_pi_reader
    import jar_pi_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [IDX_W-1:0]   target_index,
    input  logic [3:0]         count,
    output logic               pi_reset,
    output logic               pi_stream,
    output logic [CHUNK_W-1:0] pi_index,
    input  logic [7:0]         pi_segments,
    output logic [3:0]         digit,
    output logic               digit_valid,
    output logic               digit_err,
    output logic               busy,
    output logic               done
);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_target;
    logic [4:0]         r_left;
    logic [3:0]         r_digit;
    logic               r_valid;
    logic               r_err;
    logic               r_done;
    logic [3:0]         w_hex;
    logic               w_err;
    logic               w_last;

    jar_seg7dec u_dec (
        .seg (pi_segments[6:0]),
        .hex (w_hex),
        .err (w_err)
    );

    // r_left counts samples still to take, so the final one is at 1.
    assign w_last = (r_left == 5'd1);

    // State, capture and registered digit outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_target <= '0;
            r_left   <= '0;
            r_digit  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= (r_state == StStream);
            r_digit <= (r_state == StStream) ? w_hex : 4'd0;
            r_err   <= (r_state == StStream) && w_err;
            r_done  <= (r_state == StStream) && w_last;
            if (r_state == StIdle && start) begin
                r_target <= target_index;
                // count of 0 means 16
                r_left   <= {(count == 4'd0), count};
            end else if (r_state == StStream) begin
                r_left <= r_left - 5'd1;
            end
        end
    end

    // Next state and pi block controls; everything idles at 0.
    always_comb begin
        w_state_next = r_state;
        pi_reset     = 1'b0;
        pi_stream    = 1'b0;
        pi_index     = '0;
        unique case (r_state)
            StIdle: begin
                if (start) w_state_next = StLoadLo;
            end
            StLoadLo: begin
                pi_reset     = 1'b1;
                pi_index     = {r_target[3:0], 1'b0};
                w_state_next = StLoadHi;
            end
            StLoadHi: begin
                pi_reset     = 1'b1;
                pi_index     = r_target[8:4];
                w_state_next = StSettle;
            end
            StSettle: begin
                pi_stream    = 1'b1;
                w_state_next = StStream;
            end
            StStream: begin
                pi_stream = !w_last;
                if (w_last) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign busy        = (r_state != StIdle);
    assign digit       = r_digit;
    assign digit_valid = r_valid;
    assign digit_err   = r_err;
    assign done        = r_done;

endmodule

// File: tb/tb_jar_pi_reader.sv
// Self-checking bench: ramp-content pi block model plus directed/random reads.
module tb_jar_pi_reader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] target_index = '0;
    logic [3:0] count = '0;
    logic       pi_reset;
    logic       pi_stream;
    logic [4:0] pi_index;
    logic [7:0] pi_segments;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_err;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // pi block model: index loads 5 bits at a time from the top, ramp digits.
    logic [8:0] m_idx = 9'd0;
    logic [6:0] m_hex = 7'd0;
    logic       m_dp = 1'b0;
    logic       seg_zero = 1'b0;

    always @(posedge clk) begin
        m_hex <= GLYPH[m_idx[3:0]];
        m_dp  <= 1'($urandom_range(0, 1));
        if (pi_reset)       m_idx <= {pi_index, m_idx[8:5]};
        else if (pi_stream) m_idx <= m_idx + 9'd1;
    end

    assign pi_segments = seg_zero ? 8'h00 : {m_dp, m_hex};

    always #5 clk = ~clk;

    jar_pi_reader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .target_index (target_index),
        .count        (count),
        .pi_reset     (pi_reset),
        .pi_stream    (pi_stream),
        .pi_index     (pi_index),
        .pi_segments  (pi_segments),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .digit_err    (digit_err),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pi"}, {29'd0, pi_reset, pi_stream, |pi_index}, 32'd0);
        check({tag, "_out"}, {26'd0, digit, digit_valid, digit_err}, 32'd0);
        check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    endtask

    // Issue a read now (may be the done cycle of the previous one) and check every beat.
    // n is 1..16; err_beat < 0 means no forced bad pattern; poke fires a start while busy.
    task automatic do_read(input logic [8:0] t, input int n, input int err_beat, input bit poke);
        int  c;
        int  beats;
        bit  got_done;
        logic [3:0] exp_d;
        start        = 1'b1;
        target_index = t;
        count        = 4'(n);
        @(posedge clk); #1;
        start        = 1'b0;
        target_index = 9'($urandom);
        count        = 4'($urandom);
        c        = 1;
        beats    = 0;
        got_done = 1'b0;
        while (!got_done && c < 40) begin
            seg_zero = (c == 4 + err_beat);
            start    = 1'b0;
            if (c == 1) begin
                check("load_lo", {26'd0, pi_reset, pi_index}, {26'd0, 1'b1, t[3:0], 1'b0});
                check("load_lo_busy", {31'd0, busy}, 32'd1);
            end
            if (c == 2) check("load_hi", {26'd0, pi_reset, pi_index}, {26'd0, 1'b1, t[8:4]});
            if (c == 3) check("settle", {30'd0, pi_reset, pi_stream}, 32'd1);
            if (poke && c == 5) begin
                check("poke_busy", {31'd0, busy}, 32'd1);
                start        = 1'b1;
                target_index = ~t;
                count        = 4'd1;
            end
            if (digit_valid) begin
                exp_d = (beats == err_beat) ? 4'd0 : 4'((int'(t) + beats) % 16);
                check("beat_time", 32'(c), 32'(5 + beats));
                check("digit", {28'd0, digit}, {28'd0, exp_d});
                check("digit_err", {31'd0, digit_err}, {31'd0, beats == err_beat});
                check("done", {31'd0, done}, {31'd0, beats == n - 1});
                if (done) begin
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                    check("final_idx", {23'd0, m_idx}, 32'((int'(t) + n) % 512));
                end
                beats++;
            end
            if (done) got_done = 1'b1;
            else begin
                @(posedge clk); #1;
                c++;
            end
        end
        start    = 1'b0;
        seg_zero = 1'b0;
        check("beat_count", 32'(beats), 32'(n));
    endtask

    initial begin
        int n;
        int eb;
        int dones;
        logic [8:0] t;

        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // First start right after release, then back-to-back reads from the done cycle.
        do_read(9'h1A5, 3, -1, 1'b0);
        do_read(9'h1FE, 4, -1, 1'b1);
        do_read(9'($urandom), 16, -1, 1'b1);
        do_read(9'($urandom), 4, 2, 1'b0);
        @(posedge clk); #1;
        check_idle_outputs("idle");

        // Abort mid-stream with reset.
        t            = 9'($urandom);
        start        = 1'b1;
        target_index = t;
        count        = 4'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_valid_before", {31'd0, digit_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_read(9'($urandom), 5, -1, 1'b0);

        // Random reads, some with a forced bad pattern or an ignored start.
        for (int i = 0; i < 10; i++) begin
            n  = int'($urandom_range(1, 16));
            eb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            do_read(9'($urandom), n, eb, (n >= 2) && ($urandom_range(0, 1) == 1));
        end
        do_read(9'h1FF, 1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
